// File: rtl/jt5205_adpcm_pkg.sv
// Shared constants for the MSM5205-style ADPCM decoder: OKI step table,
// index adjustments, widths and the difference helper.
package jt5205_adpcm_pkg;

  localparam int unsigned SAMPLE_W = 12;
  localparam int unsigned STEP_W   = 11;
  localparam int unsigned IDX_W    = 6;
  localparam int unsigned NIB_W    = 4;
  localparam int unsigned IDX_MAX  = 48;

  localparam logic [STEP_W-1:0] STEP_TABLE [0:IDX_MAX] = '{
    11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,
    11'd31,   11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,
    11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,   11'd107,
    11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,
    11'd230,  11'd253,  11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
    11'd449,  11'd494,  11'd544,  11'd598,  11'd658,  11'd724,  11'd796,
    11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
  };

  localparam logic signed [7:0] IDX_ADJ [0:7] = '{
    -8'sd1, -8'sd1, -8'sd1, -8'sd1, 8'sd2, 8'sd4, 8'sd6, 8'sd8
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STEP,
    ST_DIFF
  } dec_state_e;

  // Magnitude-weighted step sum; the worst case fits 12 bits unsigned.
  function automatic logic [SAMPLE_W-1:0] calc_diff(input logic [STEP_W-1:0] step,
                                                    input logic [2:0]        mag);
    logic [SAMPLE_W-1:0] d;
    d = SAMPLE_W'(step >> 3);
    if (mag[0]) d = d + SAMPLE_W'(step >> 2);
    if (mag[1]) d = d + SAMPLE_W'(step >> 1);
    if (mag[2]) d = d + SAMPLE_W'(step);
    return d;
  endfunction

endpackage

// File: rtl/jt5205_adpcm_steprom.sv
// Registered step ROM: data follows the index address by one clock.
module jt5205_adpcm_steprom
  import jt5205_adpcm_pkg::*;
(
  input  logic              clk,
  input  logic [IDX_W-1:0]  addr,
  output logic [STEP_W-1:0] data
);

  always_ff @(posedge clk) begin
    data <= (addr <= IDX_W'(IDX_MAX)) ? STEP_TABLE[addr] : STEP_TABLE[IDX_MAX];
  end

endmodule

// File: rtl/jt5205_adpcm_dec.sv
// MSM5205-compatible ADPCM nibble decoder, three-stage pipeline.
// Define JT5205_ADPCM_CLAMP_EN to saturate the accumulator instead of wrapping.
module jt5205_adpcm_dec
  import jt5205_adpcm_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cen,
  input  logic [NIB_W-1:0]           din,
  input  logic                       adpcm_rst,
  output logic signed [SAMPLE_W-1:0] dout,
  output logic                       dout_vld
);

  dec_state_e                 state_q, state_d;
  logic                       accept_c, commit_c;
  logic [NIB_W-1:0]           nib_q;
  logic [IDX_W-1:0]           idx_q, idx_next_c;
  logic signed [SAMPLE_W-1:0] acc_q, acc_next_c;
  logic [STEP_W-1:0]          step;
  logic [SAMPLE_W-1:0]        diff_q;
  logic signed [SAMPLE_W:0]   sum_c;
  logic signed [7:0]          idx_sum_c;

  jt5205_adpcm_steprom u_steprom (
    .clk  (clk),
    .addr (idx_q),
    .data (step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Busy while a sample is in flight; restart flushes the pipeline.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    commit_c = 1'b0;
    if (adpcm_rst) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (cen) begin
          accept_c = 1'b1;
          state_d  = ST_STEP;
        end
        ST_STEP: state_d = ST_DIFF;
        ST_DIFF: begin
          commit_c = 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    sum_c = nib_q[3] ? ($signed({acc_q[SAMPLE_W-1], acc_q}) - $signed({1'b0, diff_q}))
                     : ($signed({acc_q[SAMPLE_W-1], acc_q}) + $signed({1'b0, diff_q}));
`ifdef JT5205_ADPCM_CLAMP_EN
    if (sum_c > 13'sd2047)       acc_next_c = 12'sh7ff;
    else if (sum_c < -13'sd2048) acc_next_c = 12'sh800;
    else                         acc_next_c = SAMPLE_W'(sum_c);
`else
    acc_next_c = SAMPLE_W'(sum_c);
`endif
    idx_sum_c = $signed({2'b00, idx_q}) + IDX_ADJ[nib_q[2:0]];
    if (idx_sum_c < 8'sd0)                 idx_next_c = '0;
    else if (idx_sum_c > 8'(IDX_MAX))      idx_next_c = IDX_W'(IDX_MAX);
    else                                   idx_next_c = IDX_W'(idx_sum_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nib_q    <= '0;
      diff_q   <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
    end else begin
      dout_vld <= 1'b0;
      if (adpcm_rst) begin
        nib_q  <= '0;
        diff_q <= '0;
        acc_q  <= '0;
        idx_q  <= '0;
        dout   <= '0;
      end else begin
        if (accept_c) nib_q <= din;
        if (state_q == ST_STEP) diff_q <= calc_diff(step, nib_q[2:0]);
        if (commit_c) begin
          acc_q    <= acc_next_c;
          idx_q    <= idx_next_c;
          dout     <= acc_next_c;
          dout_vld <= 1'b1;
        end
      end
    end
  end

endmodule
